i3c_engine_arbiter: RTL and testbench

- Shares the controller's single TX serializer, RX deserializer and register-file read port between N CCC/engine FSMs (ENTHDR, DAA, SDR private transfer, ...).
- Grants the datapath round-robin to one requesting engine and muxes that engine's control outputs onto the shared datapath. Routes datapath feedback (mode-done, ACK/NACK) back to the owner only.
- Enforces a one-cycle turnaround gap between owners and a watchdog release on hung engines.

---
 rtl/i3c_pkg.sv | 31 +++
 rtl/i3c_engine_arbiter_rr_arbiter.sv | 28 ++
 rtl/i3c_engine_arbiter.sv | 162 ++++++++++++++++
 tb/tb_i3c_engine_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i3c_pkg.sv
// Shared definitions for the I3C controller engine arbiter: engine indices,
// datapath mode codes and the arbiter state encoding.
package i3c_pkg;

  // Register-file address width carried by every engine
  localparam int REGF_ADDR_W = 10;
  localparam int TX_MODE_W   = 3;
  localparam int RX_MODE_W   = 3;

  // Engine slot assignment on the arbiter request vector
  localparam int ENG_ENTHDR  = 0;
  localparam int ENG_DAA     = 1;
  localparam int ENG_SDR     = 2;

  // TX serializer mode codes
  localparam logic [TX_MODE_W-1:0] TX_SERIALIZE = 3'b001;
  localparam logic [TX_MODE_W-1:0] TX_PARITY    = 3'b011;

  // RX deserializer mode codes
  localparam logic [RX_MODE_W-1:0] RX_ACK         = 3'b000;
  localparam logic [RX_MODE_W-1:0] RX_ARBITRATION = 3'b010;

  // Arbiter ownership phases
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_BUSY  = 2'd2,
    ST_TURN  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/i3c_engine_arbiter_rr_arbiter.sv
// Combinational round-robin pick: returns the first requester found when
// scanning upward from the pointer, wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N     = 3,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  // Scan N slots starting at the pointer; the first hit wins
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!o_valid && i_req[(int'(i_ptr) + i) % N]) begin
        o_valid                        = 1'b1;
        o_gnt[(int'(i_ptr) + i) % N]   = 1'b1;
        o_idx                          = PTR_W'((int'(i_ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/i3c_engine_arbiter.sv
// Shares the TX serializer, RX deserializer and register-file read port
// between N engine FSMs. One owner at a time, round-robin, with a one-cycle
// turnaround between owners and a watchdog that evicts a hung owner.
module i3c_engine_arbiter
  import i3c_pkg::*;
#(
  parameter int N_ENG          = 3,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int CNT_W          = 10
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_ENG-1:0]             i_req,
  input  logic [N_ENG-1:0]             i_done,
  input  logic [N_ENG-1:0]             i_regf_rd_en,
  input  logic [REGF_ADDR_W*N_ENG-1:0] i_regf_addr,
  input  logic [N_ENG-1:0]             i_tx_en,
  input  logic [TX_MODE_W*N_ENG-1:0]   i_tx_mode,
  input  logic [N_ENG-1:0]             i_rx_en,
  input  logic [RX_MODE_W*N_ENG-1:0]   i_rx_mode,
  input  logic                         i_tx_mode_done,
  input  logic                         i_rx_ack_nack,
  output logic [N_ENG-1:0]             o_gnt,
  output logic                         o_regf_rd_en,
  output logic [REGF_ADDR_W-1:0]       o_regf_addr,
  output logic                         o_tx_en,
  output logic [TX_MODE_W-1:0]         o_tx_mode,
  output logic                         o_rx_en,
  output logic [RX_MODE_W-1:0]         o_rx_mode,
  output logic [N_ENG-1:0]             o_tx_mode_done,
  output logic [N_ENG-1:0]             o_rx_ack_nack,
  output logic                         o_busy,
  output logic                         o_timeout
);

  localparam int PTR_W = $clog2(N_ENG);
  // Watchdog saturates here when the timeout is disabled
  localparam logic [CNT_W-1:0] WD_MAX   = '1;
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam bit               WD_ON    = (TIMEOUT_CYCLES != 0);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [N_ENG-1:0]  r_gnt;
  logic [PTR_W-1:0]  r_owner;
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_wdog;

  logic [N_ENG-1:0]  w_pick_gnt;
  logic [PTR_W-1:0]  w_pick_idx;
  logic              w_pick_vld;
  logic              w_owner_done;
  logic              w_wd_expire;
  logic              w_release;
  logic              w_load;

  rr_arbiter #(
    .N     (N_ENG),
    .PTR_W (PTR_W)
  ) u_rr (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  // Only the owner's completion pulse counts; other engines are masked off
  assign w_owner_done = |(r_gnt & i_done);
  assign w_wd_expire  = WD_ON && (r_state == ST_BUSY) && (r_wdog == WD_LIMIT);
  // A done coinciding with expiry is treated as a normal completion
  assign w_release    = ((r_state == ST_GRANT) && w_owner_done) ||
                        ((r_state == ST_BUSY) && (w_owner_done || w_wd_expire));
  assign w_load       = (r_state == ST_IDLE) && w_pick_vld;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_pick_vld) w_state_nxt = ST_GRANT;
      ST_GRANT: w_state_nxt = w_release ? ST_TURN : ST_BUSY;
      ST_BUSY:  if (w_release) w_state_nxt = ST_TURN;
      ST_TURN:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant vector and owner index: loaded on a pick, cleared on release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt   <= '0;
      r_owner <= '0;
    end else if (w_load) begin
      r_gnt   <= w_pick_gnt;
      r_owner <= w_pick_idx;
    end else if (w_release) begin
      r_gnt   <= '0;
    end
  end

  // Round-robin pointer moves just past the engine that released
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_release) begin
      r_ptr <= (r_owner == PTR_W'(N_ENG - 1)) ? '0 : r_owner + 1'b1;
    end
  end

  // Watchdog: idle cycles since BUSY entry or the last mode-done, saturating
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog <= '0;
    end else if (r_state == ST_BUSY) begin
      if (i_tx_mode_done) begin
        r_wdog <= '0;
      end else if (r_wdog != WD_MAX) begin
        r_wdog <= r_wdog + 1'b1;
      end
    end else begin
      r_wdog <= '0;
    end
  end

  // Status outputs and AND-OR datapath mux gated by the held grant
  always_comb begin
    o_busy       = (r_state == ST_GRANT) || (r_state == ST_BUSY);
    o_timeout    = w_wd_expire && !w_owner_done;
    o_regf_rd_en = 1'b0;
    o_regf_addr  = '0;
    o_tx_en      = 1'b0;
    o_tx_mode    = '0;
    o_rx_en      = 1'b0;
    o_rx_mode    = '0;
    for (int k = 0; k < N_ENG; k++) begin
      o_regf_rd_en = o_regf_rd_en | (i_regf_rd_en[k] & r_gnt[k]);
      o_regf_addr  = o_regf_addr  |
                     (i_regf_addr[REGF_ADDR_W*k +: REGF_ADDR_W] & {REGF_ADDR_W{r_gnt[k]}});
      o_tx_en      = o_tx_en | (i_tx_en[k] & r_gnt[k]);
      o_tx_mode    = o_tx_mode |
                     (i_tx_mode[TX_MODE_W*k +: TX_MODE_W] & {TX_MODE_W{r_gnt[k]}});
      o_rx_en      = o_rx_en | (i_rx_en[k] & r_gnt[k]);
      o_rx_mode    = o_rx_mode |
                     (i_rx_mode[RX_MODE_W*k +: RX_MODE_W] & {RX_MODE_W{r_gnt[k]}});
    end
  end

  // Feedback reaches the owner only
  assign o_gnt          = r_gnt;
  assign o_tx_mode_done = r_gnt & {N_ENG{i_tx_mode_done}};
  assign o_rx_ack_nack  = r_gnt & {N_ENG{i_rx_ack_nack}};

endmodule

// File: tb/tb_i3c_engine_arbiter.sv
// Bench for i3c_engine_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against an
// ownership model kept in the bench.
module tb_i3c_engine_arbiter;
  import i3c_pkg::*;

  localparam int N  = 3;
  localparam int TO = 20;
  localparam int CW = 10;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req, done, rd_en, tx_en, rx_en;
  logic [10*N-1:0] addr;
  logic [3*N-1:0]  tx_mode, rx_mode;
  logic          tmd, ack;

  logic [N-1:0]  gnt, o_tmd, o_ack;
  logic          o_rd, o_txen, o_rxen, busy, tmo;
  logic [9:0]    o_addr;
  logic [2:0]    o_txm, o_rxm;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: who owns the datapath and for how long
  int m_owner  = -1;
  int m_age    = 0;
  int m_silent = 0;
  int m_ptr    = 0;
  bit m_turn   = 1'b0;

  logic [29:0] e_vec, a_vec;

  i3c_engine_arbiter #(
    .N_ENG          (N),
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_done         (done),
    .i_regf_rd_en   (rd_en),
    .i_regf_addr    (addr),
    .i_tx_en        (tx_en),
    .i_tx_mode      (tx_mode),
    .i_rx_en        (rx_en),
    .i_rx_mode      (rx_mode),
    .i_tx_mode_done (tmd),
    .i_rx_ack_nack  (ack),
    .o_gnt          (gnt),
    .o_regf_rd_en   (o_rd),
    .o_regf_addr    (o_addr),
    .o_tx_en        (o_txen),
    .o_tx_mode      (o_txm),
    .o_rx_en        (o_rxen),
    .o_rx_mode      (o_rxm),
    .o_tx_mode_done (o_tmd),
    .o_rx_ack_nack  (o_ack),
    .o_busy         (busy),
    .o_timeout      (tmo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model update on each clock edge, with asynchronous reset
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = -1; m_age = 0; m_silent = 0; m_ptr = 0; m_turn = 1'b0;
    end else if (m_owner >= 0) begin
      if (done[m_owner] || (m_age >= 1 && m_silent == TO)) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_turn  = 1'b1;
      end else begin
        if (m_age >= 1) m_silent = tmd ? 0 : m_silent + 1;
        m_age++;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else if (req != '0) begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && req[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
      end
      m_age    = 0;
      m_silent = 0;
    end
  end

  // Compare every output against the model in the middle of each cycle
  initial forever begin
    @(negedge clk);
    e_vec = '0;
    if (m_owner >= 0) begin
      e_vec[29:27] = 3'(1 << m_owner);
      e_vec[26]    = rd_en[m_owner];
      e_vec[25:16] = addr[m_owner*10 +: 10];
      e_vec[15]    = tx_en[m_owner];
      e_vec[14:12] = tx_mode[m_owner*3 +: 3];
      e_vec[11]    = rx_en[m_owner];
      e_vec[10:8]  = rx_mode[m_owner*3 +: 3];
      e_vec[7:5]   = tmd ? 3'(1 << m_owner) : 3'b000;
      e_vec[4:2]   = ack ? 3'(1 << m_owner) : 3'b000;
      e_vec[1]     = 1'b1;
      e_vec[0]     = (m_age >= 1) && (m_silent == TO) && !done[m_owner];
    end
    a_vec = {gnt, o_rd, o_addr, o_txen, o_txm, o_rxen, o_rxm, o_tmd, o_ack, busy, tmo};
    n_tests++;
    if (a_vec !== e_vec) begin
      n_fail++;
      $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, a_vec, e_vec);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1, "bench time limit");
  end

  initial begin
    int ord[4];
    ord = '{ENG_ENTHDR, ENG_DAA, ENG_SDR, ENG_ENTHDR};
    req = '0; done = '0; tmd = 1'b0; ack = 1'b0;
    rd_en = 3'b111; tx_en = 3'b111; rx_en = 3'b111;
    addr    = {10'h155, 10'h2A5, 10'd46};
    tx_mode = {3'b111, TX_PARITY, TX_SERIALIZE};
    rx_mode = {3'b110, RX_ARBITRATION, RX_ACK};

    // Reset values
    repeat (3) step();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_timeout", 32'(tmo), 32'h0);
    check("rst_mux", 32'({o_rd, o_addr, o_txen, o_txm, o_rxen, o_rxm}), 32'h0);

    // Single requester, one-cycle grant latency, owner fields only
    rst_n = 1'b1;
    step();
    req = 3'b001;
    #1;
    check("lat_no_gnt_yet", 32'(gnt), 32'h0);
    step();
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_busy", 32'(busy), 32'h1);
    check("first_addr", 32'(o_addr), 32'd46);
    check("first_txmode", 32'(o_txm), 32'(TX_SERIALIZE));
    check("first_rxmode", 32'(o_rxm), 32'(RX_ACK));

    // All request; each owner completes 8 cycles after its grant
    req = 3'b111;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        tmd = 1'b1; ack = 1'b1;
        #1;
        check("fb_tx_mode_done", 32'(o_tmd), 32'h2);
        check("fb_rx_ack_nack", 32'(o_ack), 32'h2);
        tmd = 1'b0; ack = 1'b0;
      end
      repeat (7) step();
      done = 3'(1 << ord[k]);
      step();
      done = '0;
      check("turn_gnt", 32'(gnt), 32'h0);
      check("turn_busy", 32'(busy), 32'h0);
      check("turn_mux", 32'({o_rd, o_addr, o_txen, o_txm, o_rxen, o_rxm}), 32'h0);
      step();
      check("idle_gnt", 32'(gnt), 32'h0);
      step();
      check("rr_gnt", 32'(gnt), 32'(1 << ord[k+1]));
      check("rr_addr", 32'(o_addr), 32'(addr[ord[k+1]*10 +: 10]));
    end

    // Hung owner: watchdog fires 20 cycles into BUSY
    repeat (20) step();
    check("wd_not_yet", 32'(tmo), 32'h0);
    step();
    check("wd_pulse", 32'(tmo), 32'h1);
    check("wd_pulse_gnt", 32'(gnt), 32'h1);
    step();
    check("wd_release_gnt", 32'(gnt), 32'h0);
    check("wd_pulse_width", 32'(tmo), 32'h0);
    step();
    step();
    check("wd_next_owner", 32'(gnt), 32'h2);

    // Owner drops request, non-owners pulse done: no release
    req = 3'b101; done = 3'b101;
    step();
    done = '0;
    check("foreign_done_hold", 32'(gnt), 32'h2);
    repeat (19) step();
    step();
    // Owner done in the very cycle the watchdog expires
    done = 3'b010;
    #1;
    check("done_at_expiry_tmo", 32'(tmo), 32'h0);
    step();
    done = '0;
    check("done_at_expiry_rel", 32'(gnt), 32'h0);
    check("done_at_expiry_tmo2", 32'(tmo), 32'h0);
    step();
    step();
    check("ptr_after_1", 32'(gnt), 32'h4);

    // Asynchronous reset in the middle of a transfer
    repeat (3) step();
    check("pre_rst_gnt", 32'(gnt), 32'h4);
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", 32'(gnt), 32'h0);
    check("async_rst_busy", 32'(busy), 32'h0);
    check("async_rst_mux", 32'({o_rd, o_addr, o_txen, o_txm, o_rxen, o_rxm}), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    req = 3'b010;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h2);

    // Randomized traffic with varying completion and mode-done rates
    for (int seg = 0; seg < 6; seg++) begin
      int pd;
      int pt;
      pd = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 4 : 20);
      pt = (seg % 2 == 1) ? 10 : 0;
      for (int c = 0; c < 500; c++) begin
        req     = 3'($urandom);
        rd_en   = 3'($urandom);
        tx_en   = 3'($urandom);
        rx_en   = 3'($urandom);
        addr    = 30'($urandom);
        tx_mode = 9'($urandom);
        rx_mode = 9'($urandom);
        ack     = 1'($urandom);
        tmd     = ($urandom_range(0, 99) < pt);
        for (int b = 0; b < N; b++) done[b] = ($urandom_range(0, 99) < pd);
        rst_n   = ($urandom_range(0, 399) != 0);
        step();
      end
    end

    rst_n = 1'b1;
    req = '0; done = '0; tmd = 1'b0; ack = 1'b0;
    step();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
